// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between N byte-stream requesters, the round-robin arbiter and
// the shared UART transmitter.
//
// Signals:
//   tick       baud-rate tick, one clk wide
//   req_valid  [N]    requester i has a byte available
//   req_last   [N]    byte from requester i ends its packet
//   req_data   [8*N]  byte from requester i in bits [8i+7:8i]
//   req_ready  [N]    byte from requester i accepted this cycle
//   grant      [N]    one-hot current owner, zero when no owner
//   tx_start   one-cycle pulse starting transmission of tx_data
//   tx_data    [8]    byte to transmit, held until tx_done
//   tx_done    one-cycle pulse when the transmitter finishes a stop bit
//   busy       arbiter is not idle
//
// Modports:
//   slave   the arbiter side
//   master  the requester/transmitter environment side
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic           tick;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;

    modport slave (
        input  tick, req_valid, req_last, req_data, tx_done,
        output req_ready, grant, tx_start, tx_data, busy
    );

    modport master (
        output tick, req_valid, req_last, req_data, tx_done,
        input  req_ready, grant, tx_start, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N byte-stream requesters.
// Round-robin arbitration picks an owner, which keeps the transmitter until
// it sends a byte flagged last or stalls for LOCK_TIMEOUT baud ticks. Every
// packet is followed by GAP_TICKS baud ticks of idle line.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  uart_tx_arbiter_if.slave carrying tick, requester handshake,
//        grant, transmitter command/completion and busy
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int GAP_TICKS    = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int TO_W  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    // Counts leave their state on the tick that reaches the limit, so the
    // counters never pass limit-1 and cannot wrap.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;
    localparam logic [TO_W-1:0]  TO_LAST  = (LOCK_TIMEOUT > 0) ? TO_W'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             last_q, last_d;
    logic             tx_start_q, tx_start_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic             arb_found;
    logic [PTR_W-1:0] arb_winner;
    logic [PTR_W-1:0] arb_next_ptr;
    logic [N-1:0]     req_ready;
    logic             owner_valid;
    logic             handshake;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin : arb_search
        int idx;
        idx          = 0;
        arb_found    = 1'b0;
        arb_winner   = '0;
        arb_next_ptr = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!arb_found && bus.req_valid[idx]) begin
                arb_found    = 1'b1;
                arb_winner   = PTR_W'(idx);
                arb_next_ptr = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    assign owner_valid = bus.req_valid[owner_q];
    assign handshake   = (state_q == SEND) && owner_valid;

    always_comb begin
        req_ready = '0;
        if (state_q == SEND) begin
            req_ready[owner_q] = owner_valid;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            IDLE: begin
                gap_cnt_d = '0;
                to_cnt_d  = '0;
                if (arb_found) begin
                    grant_d  = {{(N-1){1'b0}}, 1'b1} << arb_winner;
                    owner_d  = arb_winner;
                    rr_ptr_d = arb_next_ptr;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    tx_data_d  = bus.req_data[{owner_q, 3'b000} +: 8];
                    last_d     = bus.req_last[owner_q];
                    tx_start_d = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = WAIT;
                end else if (LOCK_TIMEOUT != 0 && bus.tick) begin
                    // Owner is stalling: revoke the lock once the limit is hit.
                    if (to_cnt_q >= TO_LAST) begin
                        to_cnt_d  = '0;
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                // tick is deliberately ignored here; only tx_done moves on.
                if (bus.tx_done) begin
                    if (last_q) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                grant_d = '0;
                if (GAP_TICKS == 0) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    if (gap_cnt_q >= GAP_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.grant     = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// dut_a: N=4, GAP_TICKS=16, LOCK_TIMEOUT=4 (single packet, contention, lock,
//        timeout and reset scenarios).
// dut_b: N=4, GAP_TICKS=0, LOCK_TIMEOUT=64 (zero-gap back-to-back packets).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    uart_tx_arbiter_if #(.N(4)) bus_a ();
    uart_tx_arbiter_if #(.N(4)) bus_b ();

    uart_tx_arbiter #(.N(4), .GAP_TICKS(16), .LOCK_TIMEOUT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    uart_tx_arbiter #(.N(4), .GAP_TICKS(0), .LOCK_TIMEOUT(64)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.tick = 1'b1;
            step();
            bus_a.tick = 1'b0;
        end
    endtask

    task automatic done_a();
        bus_a.tx_done = 1'b1;
        step();
        bus_a.tx_done = 1'b0;
    endtask

    task automatic idle_inputs();
        bus_a.tick = 1'b0; bus_a.req_valid = '0; bus_a.req_last = '0;
        bus_a.req_data = '0; bus_a.tx_done = 1'b0;
        bus_b.tick = 1'b0; bus_b.req_valid = '0; bus_b.req_last = '0;
        bus_b.req_data = '0; bus_b.tx_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        checks++; if (bus_a.grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b expected %b", bus_a.grant, 4'b0000); else passed++;
        checks++; if (bus_a.req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected %b", bus_a.req_ready, 4'b0000); else passed++;
        checks++; if (bus_a.tx_start !== 1'b0) $display("[TB] FAIL reset_tx_start: got %b expected %b", bus_a.tx_start, 1'b0); else passed++;
        checks++; if (bus_a.tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h expected %h", bus_a.tx_data, 8'h00); else passed++;
        checks++; if (bus_a.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected %b", bus_a.busy, 1'b0); else passed++;
        checks++; if (bus_b.busy !== 1'b0) $display("[TB] FAIL reset_busy_b: got %b expected %b", bus_b.busy, 1'b0); else passed++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        bus_a.req_data  = 32'h0000_0055;
        bus_a.req_last  = 4'b0000;
        bus_a.req_valid = 4'b0001;
        step();
        checks++; if (bus_a.grant !== 4'b0001) $display("[TB] FAIL single_grant: got %b expected %b", bus_a.grant, 4'b0001); else passed++;
        checks++; if (bus_a.req_ready !== 4'b0001) $display("[TB] FAIL single_ready: got %b expected %b", bus_a.req_ready, 4'b0001); else passed++;
        step();
        checks++; if (bus_a.tx_start !== 1'b1) $display("[TB] FAIL single_start1: got %b expected %b", bus_a.tx_start, 1'b1); else passed++;
        checks++; if (bus_a.tx_data !== 8'h55) $display("[TB] FAIL single_data1: got %h expected %h", bus_a.tx_data, 8'h55); else passed++;
        bus_a.req_data = 32'h0000_00A3;
        bus_a.req_last = 4'b0001;
        checks++; if (bus_a.req_ready !== 4'b0000) $display("[TB] FAIL single_ready_wait: got %b expected %b", bus_a.req_ready, 4'b0000); else passed++;
        step();
        checks++; if (bus_a.tx_start !== 1'b0) $display("[TB] FAIL single_start_low: got %b expected %b", bus_a.tx_start, 1'b0); else passed++;
        checks++; if (bus_a.tx_data !== 8'h55) $display("[TB] FAIL single_data_hold: got %h expected %h", bus_a.tx_data, 8'h55); else passed++;
        // tick together with tx_done: tx_done alone decides the transition
        bus_a.tick = 1'b1;
        done_a();
        bus_a.tick = 1'b0;
        checks++; if (bus_a.grant !== 4'b0001) $display("[TB] FAIL single_grant_kept: got %b expected %b", bus_a.grant, 4'b0001); else passed++;
        checks++; if (bus_a.req_ready !== 4'b0001) $display("[TB] FAIL single_resend_ready: got %b expected %b", bus_a.req_ready, 4'b0001); else passed++;
        step();
        checks++; if (bus_a.tx_start !== 1'b1) $display("[TB] FAIL single_start2: got %b expected %b", bus_a.tx_start, 1'b1); else passed++;
        checks++; if (bus_a.tx_data !== 8'hA3) $display("[TB] FAIL single_data2: got %h expected %h", bus_a.tx_data, 8'hA3); else passed++;
        bus_a.req_valid = 4'b0000;
        bus_a.req_last  = 4'b0000;
        step();
        done_a();
        checks++; if (bus_a.grant !== 4'b0000) $display("[TB] FAIL single_grant_clear: got %b expected %b", bus_a.grant, 4'b0000); else passed++;
        tick_a(15);
        checks++; if (bus_a.busy !== 1'b1) $display("[TB] FAIL single_gap_busy: got %b expected %b", bus_a.busy, 1'b1); else passed++;
        tick_a(1);
        checks++; if (bus_a.busy !== 1'b0) $display("[TB] FAIL single_gap_done: got %b expected %b", bus_a.busy, 1'b0); else passed++;
    endtask

    task automatic test_contention();
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            bus_a.req_data  = 32'h3300_1100;
            bus_a.req_last  = 4'b1010;
            bus_a.req_valid = 4'b1010;
            step();
            checks++; if (bus_a.grant !== 4'b0010) $display("[TB] FAIL contention_first rep %0d: got %b expected %b", rep, bus_a.grant, 4'b0010); else passed++;
            step();
            checks++; if (bus_a.tx_data !== 8'h11) $display("[TB] FAIL contention_first_data rep %0d: got %h expected %h", rep, bus_a.tx_data, 8'h11); else passed++;
            bus_a.req_valid = 4'b1000;
            step();
            done_a();
            tick_a(16);
            step();
            checks++; if (bus_a.grant !== 4'b1000) $display("[TB] FAIL contention_second rep %0d: got %b expected %b", rep, bus_a.grant, 4'b1000); else passed++;
            step();
            checks++; if (bus_a.tx_data !== 8'h33) $display("[TB] FAIL contention_second_data rep %0d: got %h expected %h", rep, bus_a.tx_data, 8'h33); else passed++;
            bus_a.req_valid = 4'b0000;
            step();
            done_a();
            tick_a(16);
        end
    endtask

    task automatic test_lock();
        bus_a.req_data  = 32'h0072_0070;
        bus_a.req_last  = 4'b0100;
        bus_a.req_valid = 4'b0101;
        step();
        checks++; if (bus_a.grant !== 4'b0001) $display("[TB] FAIL lock_grant: got %b expected %b", bus_a.grant, 4'b0001); else passed++;
        step();
        checks++; if (bus_a.tx_data !== 8'h70) $display("[TB] FAIL lock_data1: got %h expected %h", bus_a.tx_data, 8'h70); else passed++;
        bus_a.req_data = 32'h0072_0071;
        bus_a.req_last = 4'b0101;
        checks++; if (bus_a.req_ready !== 4'b0000) $display("[TB] FAIL lock_wait_ready: got %b expected %b", bus_a.req_ready, 4'b0000); else passed++;
        step();
        done_a();
        checks++; if (bus_a.grant !== 4'b0001) $display("[TB] FAIL lock_grant_kept: got %b expected %b", bus_a.grant, 4'b0001); else passed++;
        checks++; if (bus_a.req_ready !== 4'b0001) $display("[TB] FAIL lock_no_rearb: got %b expected %b", bus_a.req_ready, 4'b0001); else passed++;
        step();
        checks++; if (bus_a.tx_data !== 8'h71) $display("[TB] FAIL lock_data2: got %h expected %h", bus_a.tx_data, 8'h71); else passed++;
        bus_a.req_valid = 4'b0100;
        step();
        done_a();
        checks++; if (bus_a.req_ready !== 4'b0000) $display("[TB] FAIL lock_gap_ready: got %b expected %b", bus_a.req_ready, 4'b0000); else passed++;
        tick_a(16);
        step();
        checks++; if (bus_a.grant !== 4'b0100) $display("[TB] FAIL lock_then_req2: got %b expected %b", bus_a.grant, 4'b0100); else passed++;
        step();
        checks++; if (bus_a.tx_data !== 8'h72) $display("[TB] FAIL lock_req2_data: got %h expected %h", bus_a.tx_data, 8'h72); else passed++;
        bus_a.req_valid = 4'b0000;
        step();
        done_a();
        tick_a(16);
    endtask

    task automatic test_timeout();
        bus_a.req_data  = 32'h3C00_1B00;
        bus_a.req_last  = 4'b0010;
        bus_a.req_valid = 4'b1010;
        step();
        checks++; if (bus_a.grant !== 4'b1000) $display("[TB] FAIL timeout_grant: got %b expected %b", bus_a.grant, 4'b1000); else passed++;
        step();
        checks++; if (bus_a.tx_data !== 8'h3C) $display("[TB] FAIL timeout_data: got %h expected %h", bus_a.tx_data, 8'h3C); else passed++;
        bus_a.req_valid = 4'b0010;
        step();
        done_a();
        tick_a(3);
        checks++; if (bus_a.grant !== 4'b1000) $display("[TB] FAIL timeout_before: got %b expected %b", bus_a.grant, 4'b1000); else passed++;
        tick_a(1);
        checks++; if (bus_a.grant !== 4'b0000) $display("[TB] FAIL timeout_revoked: got %b expected %b", bus_a.grant, 4'b0000); else passed++;
        checks++; if (bus_a.busy !== 1'b1) $display("[TB] FAIL timeout_gap_busy: got %b expected %b", bus_a.busy, 1'b1); else passed++;
        tick_a(16);
        step();
        checks++; if (bus_a.grant !== 4'b0010) $display("[TB] FAIL timeout_next_owner: got %b expected %b", bus_a.grant, 4'b0010); else passed++;
        step();
        checks++; if (bus_a.tx_data !== 8'h1B) $display("[TB] FAIL timeout_next_data: got %h expected %h", bus_a.tx_data, 8'h1B); else passed++;
        bus_a.req_valid = 4'b0000;
        step();
        done_a();
        tick_a(16);
    endtask

    task automatic test_reset_mid_wait();
        bus_a.req_data  = 32'hEE00_0000;
        bus_a.req_last  = 4'b1000;
        bus_a.req_valid = 4'b1000;
        step();
        step();
        checks++; if (bus_a.tx_start !== 1'b1) $display("[TB] FAIL rstwait_start: got %b expected %b", bus_a.tx_start, 1'b1); else passed++;
        bus_a.req_valid = 4'b0000;
        rst = 1'b0;
        #1;
        checks++; if (bus_a.grant !== 4'b0000) $display("[TB] FAIL rstwait_grant: got %b expected %b", bus_a.grant, 4'b0000); else passed++;
        checks++; if (bus_a.tx_start !== 1'b0) $display("[TB] FAIL rstwait_tx_start: got %b expected %b", bus_a.tx_start, 1'b0); else passed++;
        checks++; if (bus_a.tx_data !== 8'h00) $display("[TB] FAIL rstwait_tx_data: got %h expected %h", bus_a.tx_data, 8'h00); else passed++;
        checks++; if (bus_a.busy !== 1'b0) $display("[TB] FAIL rstwait_busy: got %b expected %b", bus_a.busy, 1'b0); else passed++;
        step();
        rst = 1'b1;
        step();
        done_a();
        checks++; if (bus_a.busy !== 1'b0) $display("[TB] FAIL rstwait_done_ignored: got %b expected %b", bus_a.busy, 1'b0); else passed++;
        bus_a.req_data  = 32'h0000_0000;
        bus_a.req_last  = 4'b0101;
        bus_a.req_valid = 4'b0101;
        step();
        checks++; if (bus_a.grant !== 4'b0001) $display("[TB] FAIL rstwait_rr_cleared: got %b expected %b", bus_a.grant, 4'b0001); else passed++;
        bus_a.req_valid = 4'b0000;
        apply_reset();
    endtask

    task automatic test_gap_zero();
        bus_b.req_data  = 32'h0000_0001;
        bus_b.req_last  = 4'b0001;
        bus_b.req_valid = 4'b0001;
        step();
        checks++; if (bus_b.grant !== 4'b0001) $display("[TB] FAIL gap0_grant: got %b expected %b", bus_b.grant, 4'b0001); else passed++;
        step();
        checks++; if (bus_b.tx_data !== 8'h01) $display("[TB] FAIL gap0_data1: got %h expected %h", bus_b.tx_data, 8'h01); else passed++;
        bus_b.req_data = 32'h0000_0002;
        step();
        bus_b.tx_done = 1'b1;
        step();
        bus_b.tx_done = 1'b0;
        checks++; if (bus_b.req_ready !== 4'b0000) $display("[TB] FAIL gap0_gap_cycle: got %b expected %b", bus_b.req_ready, 4'b0000); else passed++;
        checks++; if (bus_b.busy !== 1'b1) $display("[TB] FAIL gap0_gap_busy: got %b expected %b", bus_b.busy, 1'b1); else passed++;
        step();
        checks++; if (bus_b.req_ready !== 4'b0000) $display("[TB] FAIL gap0_idle_cycle: got %b expected %b", bus_b.req_ready, 4'b0000); else passed++;
        checks++; if (bus_b.busy !== 1'b0) $display("[TB] FAIL gap0_idle_busy: got %b expected %b", bus_b.busy, 1'b0); else passed++;
        step();
        checks++; if (bus_b.req_ready !== 4'b0001) $display("[TB] FAIL gap0_ready_again: got %b expected %b", bus_b.req_ready, 4'b0001); else passed++;
        step();
        checks++; if (bus_b.tx_data !== 8'h02) $display("[TB] FAIL gap0_data2: got %h expected %h", bus_b.tx_data, 8'h02); else passed++;
        bus_b.req_valid = 4'b0000;
        step();
        bus_b.tx_done = 1'b1;
        step();
        bus_b.tx_done = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid_wait();
        test_gap_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N byte-stream requesters using round-robin arbitration with packet locking.
- A granted requester keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requester logic and the UART transmitter. It issues one-byte transmit commands, waits for completion, and enforces an inter-packet idle gap counted in baud ticks.

Parameters:
- N, 4, number of requesters (2..8).
- GAP_TICKS, 16, baud ticks of idle time after each packet (0 = no gap).
- LOCK_TIMEOUT, 64, baud ticks a locked requester may stall before its grant is revoked (0 = never revoke).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  baud-rate tick, one clk wide; the same tick that drives the UART datapath.
- req_valid  in  N  requester i has a byte available.
- req_last  in  N  the byte from requester i ends its packet.
- req_data  in  8*N  byte from requester i, carried in bits [8i+7:8i].
- req_ready  out  N  byte from requester i accepted this cycle.
- grant  out  N  one-hot current owner; all zeros when no owner.
- tx_start  out  1  one-cycle pulse that starts transmission of tx_data.
- tx_data  out  8  byte to transmit; held stable until tx_done.
- tx_done  in  1  one-cycle pulse from the transmitter when its stop bit completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, SEND, WAIT, GAP. All are registered.
- Reset while rst=0, any state, mid-byte included:
  - state=IDLE; grant, req_ready, tx_start, tx_data all 0.
  - rr_ptr=0; gap and timeout counters cleared.
  - Any byte in flight at the transmitter is abandoned. A tx_done arriving after reset is ignored.
- IDLE:
  - If any req_valid is set, choose the first set index searching from rr_ptr upward, with wrap-around modulo N.
  - On that edge: grant becomes one-hot at that index, rr_ptr=(winner+1) mod N, state goes to SEND.
  - Arbitration costs exactly one cycle.
- SEND, with owner g:
  - req_ready[g] = req_valid[g] && state==SEND. This is combinational from registered state; all other req_ready bits are 0.
  - On handshake: tx_data<=req_data[g], last_q<=req_last[g], tx_start pulses high on the next cycle, state goes to WAIT.
  - Handshake-to-tx_start latency is 1 cycle.
  - If req_valid[g]=0, the timeout counter increments on each tick. When it reaches LOCK_TIMEOUT, grant clears and state goes to GAP.
  - The timeout counter clears on every handshake.
- WAIT:
  - Hold tx_data and grant.
  - On tx_done: go to GAP if last_q=1, otherwise return to SEND with the grant kept. The lock prevents other requesters from interleaving.
  - tx_done in any other state is ignored.
- GAP:
  - grant=0; count ticks. After GAP_TICKS ticks go to IDLE.
  - With GAP_TICKS=0, GAP lasts exactly one cycle.
  - Requests arriving during GAP wait.
- Fairness: after any requester is served, it has lowest priority at the next arbitration. Requests that are held pending are served within N packets.
- Counters are sized to hold their parameter value; the gap counter and timeout counter saturate and never wrap.
- tick and tx_done in the same cycle are legal. tx_done decides the transition; tick is ignored by WAIT.
- Changes to req_data or req_last while not handshaking have no effect.

Test Plan:
- Single packet: req 0 sends 0x55 then 0xA3 with last.
  - tx_start pulses with tx_data=0x55, then with 0xA3 after the first tx_done.
  - grant stays 0001 throughout, then clears; busy falls after 16 ticks.
- Contention: req 1 and req 3 both valid with single-byte packets, rr_ptr=0.
  - Order is 1 then 3. Repeating the pair gives 1 then 3 again, since rr_ptr=0 after req 3 wins.
- Lock: req 0 sends a non-last byte while req 2 is valid.
  - Req 2 receives no ready until req 0's last byte completes.
  - Req 0's second byte is accepted with no re-arbitration cycle.
- Timeout: LOCK_TIMEOUT=4; owner drops req_valid after a non-last byte.
  - After 4 ticks grant goes to 0, then GAP, then another requester is served.
- Reset mid-WAIT: assert rst low after tx_start.
  - All outputs go to 0 immediately. A later tx_done is ignored; state stays IDLE.
  - After release, req 0 wins a contention with req 2.
- GAP_TICKS=0: two back-to-back single-byte packets from the same requester.
  - Exactly one GAP cycle plus one IDLE arbitration cycle separate the tx_done from the next req_ready.
